// File: rtl/apps_torque_gate.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apps_torque_gate: APPS plausibility, brake-cut and torque gating FSM.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module apps_torque_gate #(
   parameter logic [11:0] BRAKE_THRESHOLD = 12'd2,
   parameter logic [11:0] APPS_HIGH       = 12'd1024,
   parameter logic [11:0] APPS_LOW        = 12'd205,
   parameter logic [11:0] DEV_THRESHOLD   = 12'd410,
   parameter logic [11:0] OOR_LOW         = 12'd40,
   parameter logic [11:0] OOR_HIGH        = 12'd4055,
   parameter logic [15:0] IMPLAUS_CYCLES  = 16'd5000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ready_to_drive,
   input  logic [11:0] bse,
   input  logic [11:0] apps1,
   input  logic [11:0] apps2,
   output logic [11:0] torque_cmd,
   output logic        torque_enable,
   output logic        brake_cut,
   output logic        apps_fault
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DRIVE      = 2'd1,
      BRAKE_CUT  = 2'd2,
      APPS_FAULT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] imp_cnt_q, imp_cnt_d;
   logic [11:0] torque_cmd_q, torque_cmd_d;
   logic        torque_enable_q, torque_enable_d;
   logic        brake_cut_q, brake_cut_d;
   logic        apps_fault_q, apps_fault_d;

   logic [12:0] apps_sum;
   logic [11:0] pedal;
   logic [12:0] diff;
   logic [12:0] diff_mag;
   logic        out_of_range;
   logic        implausible;
   logic        imp_trip;
   logic        brake_on;

   // Average of both channels; the 13-bit sum cannot overflow.
   assign apps_sum = {1'b0, apps1} + {1'b0, apps2};
   assign pedal    = apps_sum[12:1];

   assign diff     = {1'b0, apps1} - {1'b0, apps2};
   assign diff_mag = diff[12] ? (13'd0 - diff) : diff;

   assign out_of_range = (apps1 < OOR_LOW) || (apps1 > OOR_HIGH) ||
                         (apps2 < OOR_LOW) || (apps2 > OOR_HIGH);
   assign implausible  = (diff_mag > {1'b0, DEV_THRESHOLD}) || out_of_range;
   assign imp_trip     = implausible && (imp_cnt_q == IMPLAUS_CYCLES);
   assign brake_on     = bse > BRAKE_THRESHOLD;

   always_comb begin
      state_d = state_q;

      if (!implausible) begin
         imp_cnt_d = 16'd0;
      end else if (imp_cnt_q == IMPLAUS_CYCLES) begin
         imp_cnt_d = imp_cnt_q;
      end else begin
         imp_cnt_d = imp_cnt_q + 16'd1;
      end

      case (state_q)
         IDLE: begin
            imp_cnt_d = 16'd0;
            if (ready_to_drive && (pedal < APPS_LOW) && !implausible) begin
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (!ready_to_drive) begin
               state_d = IDLE;
            end else if (imp_trip) begin
               state_d = APPS_FAULT;
            end else if (brake_on && (pedal > APPS_HIGH)) begin
               state_d = BRAKE_CUT;
            end
         end
         BRAKE_CUT: begin
            if (!ready_to_drive) begin
               state_d = IDLE;
            end else if (imp_trip) begin
               state_d = APPS_FAULT;
            end else if (pedal < APPS_LOW) begin
               state_d = DRIVE;
            end
         end
         APPS_FAULT: begin
            if (!ready_to_drive) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs follow the next state so they settle with the state register.
      torque_enable_d = (state_d == DRIVE);
      torque_cmd_d    = (state_d == DRIVE) ? pedal : 12'd0;
      brake_cut_d     = (state_d == BRAKE_CUT);
      apps_fault_d    = (state_d == APPS_FAULT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         imp_cnt_q       <= 16'd0;
         torque_cmd_q    <= 12'd0;
         torque_enable_q <= 1'b0;
         brake_cut_q     <= 1'b0;
         apps_fault_q    <= 1'b0;
      end else begin
         state_q         <= state_d;
         imp_cnt_q       <= imp_cnt_d;
         torque_cmd_q    <= torque_cmd_d;
         torque_enable_q <= torque_enable_d;
         brake_cut_q     <= brake_cut_d;
         apps_fault_q    <= apps_fault_d;
      end
   end

   assign torque_cmd    = torque_cmd_q;
   assign torque_enable = torque_enable_q;
   assign brake_cut     = brake_cut_q;
   assign apps_fault    = apps_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_apps_torque_gate.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_apps_torque_gate: directed self-checking bench for apps_torque_gate.   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_apps_torque_gate;

   logic        clk;
   logic        rst;
   logic        ready_to_drive;
   logic [11:0] bse;
   logic [11:0] apps1;
   logic [11:0] apps2;
   logic [11:0] torque_cmd;
   logic        torque_enable;
   logic        brake_cut;
   logic        apps_fault;

   int n_checks;
   int n_fail;

   // Observed outputs packed as {torque_enable, brake_cut, apps_fault, torque_cmd}.
   logic [14:0] obs;
   assign obs = {torque_enable, brake_cut, apps_fault, torque_cmd};

   apps_torque_gate #(
      .IMPLAUS_CYCLES (16'd4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ready_to_drive (ready_to_drive),
      .bse            (bse),
      .apps1          (apps1),
      .apps2          (apps2),
      .torque_cmd     (torque_cmd),
      .torque_enable  (torque_enable),
      .brake_cut      (brake_cut),
      .apps_fault     (apps_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic rtd, input int a1, input int a2, input int b);
      ready_to_drive = rtd;
      apps1          = 12'(a1);
      apps2          = 12'(a2);
      bse            = 12'(b);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_in(1'b0, 100, 100, 0);
      tick();
      tick();
      n_checks++;
      if (obs !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected %h", obs, 15'd0);
      end
      #2 rst = 1'b0;
      tick();
   endtask

   task automatic test_basic_drive();
      set_in(1'b1, 100, 100, 0);
      tick();
      n_checks++;
      if (obs !== {3'b100, 12'd100}) begin
         n_fail++;
         $display("FAIL basic_drive: got %h expected %h", obs, {3'b100, 12'd100});
      end
   endtask

   task automatic test_pedal_release();
      set_in(1'b0, 100, 100, 0);
      tick();
      n_checks++;
      if (obs !== 15'd0) begin
         n_fail++;
         $display("FAIL rtd_drop_idle: got %h expected %h", obs, 15'd0);
      end
      set_in(1'b1, 600, 600, 0);
      tick();
      tick();
      n_checks++;
      if (obs !== 15'd0) begin
         n_fail++;
         $display("FAIL pedal_held_idle: got %h expected %h", obs, 15'd0);
      end
      set_in(1'b1, 100, 100, 0);
      tick();
      n_checks++;
      if (obs !== {3'b100, 12'd100}) begin
         n_fail++;
         $display("FAIL pedal_release_drive: got %h expected %h", obs, {3'b100, 12'd100});
      end
   endtask

   task automatic test_brake_cut();
      set_in(1'b1, 2000, 2000, 2);
      tick();
      n_checks++;
      if (obs !== {3'b100, 12'd2000}) begin
         n_fail++;
         $display("FAIL bse_eq_threshold: got %h expected %h", obs, {3'b100, 12'd2000});
      end
      set_in(1'b1, 2000, 2000, 50);
      tick();
      n_checks++;
      if (obs !== {3'b010, 12'd0}) begin
         n_fail++;
         $display("FAIL brake_cut_enter: got %h expected %h", obs, {3'b010, 12'd0});
      end
      set_in(1'b1, 2000, 2000, 0);
      tick();
      n_checks++;
      if (obs !== {3'b010, 12'd0}) begin
         n_fail++;
         $display("FAIL brake_cut_hold: got %h expected %h", obs, {3'b010, 12'd0});
      end
      set_in(1'b1, 205, 205, 0);
      tick();
      n_checks++;
      if (obs !== {3'b010, 12'd0}) begin
         n_fail++;
         $display("FAIL brake_cut_at_low: got %h expected %h", obs, {3'b010, 12'd0});
      end
      set_in(1'b1, 204, 204, 0);
      tick();
      n_checks++;
      if (obs !== {3'b100, 12'd204}) begin
         n_fail++;
         $display("FAIL brake_cut_clear: got %h expected %h", obs, {3'b100, 12'd204});
      end
      set_in(1'b1, 1024, 1024, 50);
      tick();
      n_checks++;
      if (obs !== {3'b100, 12'd1024}) begin
         n_fail++;
         $display("FAIL pedal_eq_high: got %h expected %h", obs, {3'b100, 12'd1024});
      end
      // Odd sum: (1025+1026)>>1 = 1025, just above the threshold.
      set_in(1'b1, 1025, 1026, 50);
      tick();
      n_checks++;
      if (obs !== {3'b010, 12'd0}) begin
         n_fail++;
         $display("FAIL pedal_above_high: got %h expected %h", obs, {3'b010, 12'd0});
      end
      set_in(1'b1, 100, 100, 0);
      tick();
   endtask

   task automatic test_implaus_fault();
      set_in(1'b1, 1000, 1500, 0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         n_checks++;
         if (obs !== {3'b100, 12'd1250}) begin
            n_fail++;
            $display("FAIL implaus_sample_%0d: got %h expected %h", i, obs, {3'b100, 12'd1250});
         end
      end
      tick();
      n_checks++;
      if (obs !== {3'b001, 12'd0}) begin
         n_fail++;
         $display("FAIL implaus_fault: got %h expected %h", obs, {3'b001, 12'd0});
      end
      set_in(1'b1, 100, 100, 0);
      tick();
      n_checks++;
      if (obs !== {3'b001, 12'd0}) begin
         n_fail++;
         $display("FAIL fault_latched: got %h expected %h", obs, {3'b001, 12'd0});
      end
      set_in(1'b0, 100, 100, 0);
      tick();
      n_checks++;
      if (obs !== 15'd0) begin
         n_fail++;
         $display("FAIL fault_clear_rtd: got %h expected %h", obs, 15'd0);
      end
      set_in(1'b1, 100, 100, 0);
      tick();
   endtask

   task automatic test_counter_clear();
      set_in(1'b1, 1000, 1500, 0);
      repeat (4) tick();
      set_in(1'b1, 1000, 1000, 0);
      tick();
      set_in(1'b1, 1000, 1500, 0);
      repeat (4) tick();
      n_checks++;
      if (obs !== {3'b100, 12'd1250}) begin
         n_fail++;
         $display("FAIL counter_cleared: got %h expected %h", obs, {3'b100, 12'd1250});
      end
      // |diff| exactly at the threshold stays plausible indefinitely.
      set_in(1'b1, 500, 910, 0);
      repeat (6) tick();
      n_checks++;
      if (obs !== {3'b100, 12'd705}) begin
         n_fail++;
         $display("FAIL diff_eq_threshold: got %h expected %h", obs, {3'b100, 12'd705});
      end
      set_in(1'b1, 4090, 4090, 0);
      repeat (4) tick();
      n_checks++;
      if (obs !== {3'b100, 12'd4090}) begin
         n_fail++;
         $display("FAIL oor_sample_4: got %h expected %h", obs, {3'b100, 12'd4090});
      end
      tick();
      n_checks++;
      if (obs !== {3'b001, 12'd0}) begin
         n_fail++;
         $display("FAIL oor_fault: got %h expected %h", obs, {3'b001, 12'd0});
      end
      set_in(1'b0, 100, 100, 0);
      tick();
      set_in(1'b1, 100, 100, 0);
      tick();
   endtask

   task automatic test_simul_drop();
      set_in(1'b1, 1000, 1500, 50);
      repeat (4) tick();
      n_checks++;
      if (obs !== {3'b010, 12'd0}) begin
         n_fail++;
         $display("FAIL cut_before_drop: got %h expected %h", obs, {3'b010, 12'd0});
      end
      set_in(1'b0, 1000, 1500, 50);
      tick();
      n_checks++;
      if (obs !== 15'd0) begin
         n_fail++;
         $display("FAIL drop_beats_trip: got %h expected %h", obs, 15'd0);
      end
   endtask

   task automatic test_async_reset();
      set_in(1'b1, 100, 100, 0);
      tick();
      set_in(1'b1, 300, 300, 0);
      tick();
      n_checks++;
      if (obs !== {3'b100, 12'd300}) begin
         n_fail++;
         $display("FAIL pre_reset_drive: got %h expected %h", obs, {3'b100, 12'd300});
      end
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (obs !== 15'd0) begin
         n_fail++;
         $display("FAIL async_reset: got %h expected %h", obs, 15'd0);
      end
      set_in(1'b1, 100, 100, 0);
      #1 rst = 1'b0;
      tick();
      n_checks++;
      if (obs !== {3'b100, 12'd100}) begin
         n_fail++;
         $display("FAIL post_reset_drive: got %h expected %h", obs, {3'b100, 12'd100});
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      set_in(1'b0, 100, 100, 0);
      test_reset();
      test_basic_drive();
      test_pedal_release();
      test_brake_cut();
      test_implaus_fault();
      test_counter_clear();
      test_simul_drop();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
